// File: rtl/data_ram_ctrl_pkg.sv
// Shared widths, FSM encodings and control constants for the data-side RAM responder.
// The 2-bit state encodings stay compatible with the legacy DRAM_* defines.
package data_ram_ctrl_pkg;

    localparam int DataAddrBus    = 32;
    localparam int DataBus        = 32;
    localparam int DataMemNumLog2 = 10;

    localparam logic [1:0] DRAM_IDLE = 2'b00;
    localparam logic [1:0] DRAM_BUSY = 2'b01;
    localparam logic [1:0] DRAM_DONE = 2'b10;

    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    localparam logic [DataBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/data_ram_array.sv
// Word-organised RAM built from four 8-bit banks.
// Each bank has a per-lane synchronous write and a registered synchronous read.
module data_ram_array
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DataMemNumLog2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            sel,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DataBus-1:0]    wdata,
    output logic [DataBus-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Lane l holds data bits [8l+7:8l]; sel[3] is the big-endian offset-0 byte.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (we && sel[l]) begin
                r_mem[idx] <= wdata[8*l +: 8];
            end
            r_q <= r_mem[idx];
        end

        assign rdata[8*l +: 8] = r_q;
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data-side memory responder: latches one MEM-stage request, waits WAIT_CYCLES,
// performs the byte-lane access, and holds stallreq until the data is ready.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = DataMemNumLog2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   we,
    input  logic [DataAddrBus-1:0] addr,
    input  logic [3:0]             sel,
    input  logic [DataBus-1:0]     data_i,
    output logic [DataBus-1:0]     data_o,
    output logic                   stallreq
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_sel;
    logic                  r_we;
    logic [DataBus-1:0]    r_wdata;

    logic [ADDR_WIDTH-1:0] w_addr_idx;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_ram_we;
    logic [DataBus-1:0]    w_rdata;
    logic                  w_unused_addr;

    assign w_addr_idx    = addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{addr[DataAddrBus-1:ADDR_WIDTH+2], addr[1:0]};

    assign w_accept = (r_state == DRAM_IDLE) && (ce == ChipEnable);
    assign w_access = (r_state == DRAM_BUSY) && (r_cnt == 4'd0);
    // A reset on the access edge abandons the write.
    assign w_ram_we = w_access && (r_we == WriteEnable) && rst;

    // Steering the live address in IDLE primes the registered read at the accept
    // edge, so the word is already in rdata even when WAIT_CYCLES is 0.
    assign w_ram_idx = (r_state == DRAM_IDLE) ? w_addr_idx : r_idx;

    always_comb begin
        stallreq = 1'b0;
        case (r_state)
            DRAM_IDLE: stallreq = ce;
            DRAM_BUSY: stallreq = 1'b1;
            default:   stallreq = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= DRAM_IDLE;
            r_cnt   <= 4'd0;
            data_o  <= ZeroWord;
        end else begin
            case (r_state)
                DRAM_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= WAIT_INIT;
                        r_state <= DRAM_BUSY;
                    end
                end
                DRAM_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (r_we != WriteEnable) begin
                            data_o <= w_rdata;
                        end
                        r_state <= DRAM_DONE;
                    end
                end
                default: r_state <= DRAM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= w_addr_idx;
            r_sel   <= sel;
            r_we    <= we;
            r_wdata <= data_i;
        end
    end

    data_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (w_ram_we),
        .sel  (r_sel),
        .idx  (w_ram_idx),
        .wdata(r_wdata),
        .rdata(w_rdata)
    );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Randomised and directed bench for data_ram_ctrl at WAIT_CYCLES 2 and 0,
// checked against a word-array reference model of the memory and stall timing.
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic        dsel = 1'b0;

    logic        ce0, ce1, stall0, stall1, stall;
    logic [31:0] dout0, dout1, dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m  [2][1024];
    logic [31:0] dout_m [2];

    always #5 clk = ~clk;

    assign ce0   = ce & ~dsel;
    assign ce1   = ce & dsel;
    assign stall = dsel ? stall1 : stall0;
    assign dout  = dsel ? dout1 : dout0;

    data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(dout0), .stallreq(stall0)
    );

    data_ram_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .ce(ce1), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(dout1), .stallreq(stall1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One complete transaction on the selected DUT; entered and left mid-cycle in IDLE.
    task automatic access(input bit d, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] di, input bit flush);
        int n;
        int wc;
        int idx;
        logic [31:0] word;
        wc  = d ? 0 : 2;
        idx = int'(a[11:2]);
        dsel = d; ce = 1'b1; we = w; addr = a; sel = s; data_i = di;
        #1;
        check("stall_cycle0", {31'd0, stall}, 32'd1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (flush && k == 0) ce = 1'b0;
            #1;
            if (!stall) break;
            n++;
        end
        check("stall_len", n, wc + 2);
        if (w) begin
            word = mem_m[d][idx];
            for (int l = 0; l < 4; l++)
                if (s[l]) word[8*l +: 8] = di[8*l +: 8];
            mem_m[d][idx] = word;
        end else begin
            dout_m[d] = mem_m[d][idx];
        end
        check(w ? "dout_hold" : "read_data", dout, dout_m[d]);
        @(posedge clk); #1;
        ce = 1'b0;
        #1;
        check("no_reaccept", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [9:0]  pool [8];
        bit d, w, fl;
        int p;

        dout_m[0] = '0;
        dout_m[1] = '0;
        for (int i = 0; i < 8; i++) pool[i] = 10'(i * 37 + 5);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_dout0", dout0, 32'h0);
        check("rst_dout1", dout1, 32'h0);
        check("rst_stall", {31'd0, stall0 | stall1}, 32'd0);

        // Directed lane writes at WAIT_CYCLES=2
        access(0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
        access(0, 0, 32'h100, 4'b0000, 32'h0, 0);
        check("word_write", dout, 32'hDEADBEEF);
        access(0, 1, 32'h101, 4'b0100, 32'h55555555, 0);
        access(0, 0, 32'h100, 4'b1111, 32'h0, 0);
        check("byte_write", dout, 32'hDE55BEEF);
        access(0, 1, 32'h102, 4'b0011, 32'h12341234, 0);
        access(0, 0, 32'h100, 4'b0001, 32'h0, 0);
        check("half_write", dout, 32'hDE551234);
        access(0, 1, 32'h100, 4'b0000, 32'hFFFFFFFF, 0);
        access(0, 0, 32'h100, 4'b1111, 32'h0, 0);
        check("sel0_write", dout, 32'hDE551234);

        // Reset on the access edge of a pending write drops it
        dsel = 0; ce = 1'b1; we = 1'b1; addr = 32'h100; sel = 4'b1111; data_i = 32'h11111111;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_dout", dout, 32'h0);
        check("rst_mid_stall_ce", {31'd0, stall}, 32'd1);
        ce = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        dout_m[0] = '0;
        access(0, 0, 32'h100, 4'b1111, 32'h0, 0);
        check("rst_dropped_write", dout, 32'hDE551234);

        // Flush mid-access and aliasing on both DUTs
        for (int dd = 0; dd < 2; dd++) begin
            access(dd[0], 1, 32'h4, 4'b1111, 32'hA5A5A5A5, 1);
            access(dd[0], 0, 32'h1004, 4'b1111, 32'h0, 0);
            check("flush_alias", dout, 32'hA5A5A5A5);
        end

        // Initialise the random pool, then random traffic
        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < 8; i++)
                access(dd[0], 1, {20'd0, pool[i], 2'b00}, 4'b1111, $urandom, 0);
        for (int i = 0; i < 80; i++) begin
            r  = $urandom;
            d  = $urandom_range(0, 1) == 1;
            w  = $urandom_range(0, 1) == 1;
            fl = $urandom_range(0, 3) == 0;
            p  = $urandom_range(0, 7);
            access(d, w, {r[31:12], pool[p], r[1:0]}, 4'($urandom), $urandom, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Data-side memory responder for the five-stage pipeline: services the word address, byte selects, write enable, chip enable and store data driven by the MEM stage, and returns the full read word for MEM to extract and sign- or zero-extend. Internally it holds a word-organised, byte-lane-writable RAM behind a small access FSM with a programmable wait-state count. While an access is in flight it raises `stallreq` toward the stall controller, so the pipeline holds MEM inputs stable until the data is ready.

## Interface
- `ADDR_WIDTH`, 10, word-address bits; depth = 2^ADDR_WIDTH words (4 KiB at default)
- `WAIT_CYCLES`, 2, extra busy cycles per access, legal range 0..15
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `ce`  in  1  chip enable; high = access requested
- `we`  in  1  1 = write, 0 = read; sampled with `ce`
- `addr`  in  32  byte address; bits [ADDR_WIDTH+1:2] index the array, [1:0] and upper bits ignored
- `sel`  in  4  byte-lane enables, big-endian: `sel[3]` ↔ data[31:24] ↔ byte offset 0, `sel[0]` ↔ data[7:0] ↔ offset 3
- `data_i`  in  32  store data, already lane-replicated/aligned by MEM
- `data_o`  out  32  read word, registered
- `stallreq`  out  1  high while a request is outstanding

## Operation
- FSM states: IDLE, BUSY, DONE; 4-bit wait counter `cnt`.
- IDLE: `stallreq = ce` (combinational). On `ce=1`: latch word index, `sel`, `we`, `data_i`; `cnt <= WAIT_CYCLES`; go to BUSY. On `ce=0`: stay.
- BUSY: `stallreq=1`. If `cnt != 0`: decrement. If `cnt == 0`: perform the access at this edge and go to DONE.
  - Write: update only lanes with latched `sel` bit set; other bytes keep their value. `sel=4'b0000` writes nothing but still completes.
  - Read: `data_o <=` full word at latched index, whatever the `sel` value.
- DONE: `stallreq=0`, so the pipeline advances at this edge; next state is IDLE unconditionally. The request still visible on the inputs during DONE is never re-accepted.
- Inputs are ignored outside IDLE. A latched access always completes, even if `ce` drops mid-access (flush).
- `data_o` holds its value through writes and idle cycles, and changes only when a read completes.
- Addresses beyond depth wrap modulo 2^ADDR_WIDTH words.

## Timing
- Reset (`rst=0` at edge): state IDLE, `cnt=0`, `data_o=32'h0`. `stallreq` is then `ce`-driven combinationally (0 when `ce=0`). Any pending write is dropped. Array contents are not cleared.
- Reset mid-BUSY: the access is abandoned and no array write happens.
- Request accepted in cycle 0 (IDLE, `ce=1`): BUSY occupies cycles 1..WAIT_CYCLES+1, the access occurs at the end of cycle WAIT_CYCLES+1, and DONE is cycle WAIT_CYCLES+2.
- `stallreq` is high for cycles 0..WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles; read data is valid on `data_o` from DONE onward.
- Back-to-back accesses: minimum period is WAIT_CYCLES+3 cycles (DONE→IDLE→accept).
- A read following a write to the same word returns the written data. There is no forwarding hazard, because accesses are serialised.

## Structure
- `defines.v` additions: `DataAddrBus`, `DataMemNumLog2` (=ADDR_WIDTH default), FSM state encodings `DRAM_IDLE/DRAM_BUSY/DRAM_DONE` (2-bit), plus reuse of `ChipEnable`, `WriteEnable`, and `ZeroWord`.
- One sub-module, `data_ram_array`: four 8-bit banks, synchronous per-lane write, synchronous registered read, with ports `clk, we, sel, idx, wdata, rdata`.
- `data_ram_ctrl` owns the FSM, the counter, the request latch and `stallreq`.

## Test plan
- Reset with `ce=1` and a write pending in BUSY, then `rst=0` → `data_o=0`, state IDLE; a subsequent read of that word shows the old contents.
- Word write: WAIT_CYCLES=2, `addr=32'h100`, `sel=4'b1111`, `data_i=32'hDEADBEEF`. Expect `stallreq` high for exactly 4 cycles; a later read of `32'h100` returns `32'hDEADBEEF` in DONE.
- Byte write: on top of the previous case, `addr=32'h101`, `sel=4'b0100`, `data_i=32'h55555555` → read of `32'h100` gives `32'hDE55BEEF`.
- Halfword write: `sel=4'b0011`, `data_i=32'h12341234` → word becomes `32'hDE551234`. A `sel=4'b0000` write leaves it unchanged and still completes in 4 cycles.
- WAIT_CYCLES=0: read accepted → `stallreq` high for 2 cycles, and data is valid in cycle 2. Holding `ce=1` through DONE causes no re-accept; the next request is accepted in cycle 3.
- `ce` dropped in BUSY during a write of `32'hA5A5A5A5` to `addr=32'h4` → the write still lands. An access to `addr = 4·2^ADDR_WIDTH + 4` aliases the same word.
